// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU, debug) arbiter in front of a single-port synchronous RAM.
// Each access runs IDLE -> ACCESS -> RESP, which gives one access every three cycles.
// Define MEM_ARBITER_RR_EN for round-robin contention; by default the CPU always wins.
module mem_arbiter #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cpu_mem_cmd,
  input  logic [AW-1:0] cpu_mem_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DBG = 1'b1;

  state_t        state;
  logic          last_grant;   // port served by the current/most recent access
  logic          rd_q;         // current access is a read
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dbg_rdata_q;
  logic          cpu_req;
  logic          cpu_wins;

  // Command 11 is treated as no request.
  assign cpu_req   = (cpu_mem_cmd == 2'b01) || (cpu_mem_cmd == 2'b10);
  assign cpu_stall = cpu_req && !cpu_ack;

`ifdef MEM_ARBITER_RR_EN
  // Round-robin: on contention the port not served last time wins.
  assign cpu_wins = cpu_req && (!dbg_req || (last_grant == GRANT_DBG));
`else
  // Fixed priority: the CPU wins every contention.
  assign cpu_wins = cpu_req;
`endif

  // RAM read data reaches the winner during RESP, then the captured copy is held.
  assign cpu_rdata = (state == RESP && last_grant == GRANT_CPU && rd_q) ? ram_dout : cpu_rdata_q;
  assign dbg_rdata = (state == RESP && last_grant == GRANT_DBG && rd_q) ? ram_dout : dbg_rdata_q;

  // Arbitration FSM with registered RAM controls and ack pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= GRANT_DBG;
      rd_q        <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      ram_we      <= 1'b0;
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          if (cpu_req || dbg_req) begin
            state <= ACCESS;
            if (cpu_wins) begin
              ram_addr   <= cpu_mem_addr;
              ram_din    <= cpu_wdata;
              ram_we     <= (cpu_mem_cmd == 2'b01);
              rd_q       <= (cpu_mem_cmd == 2'b10);
              last_grant <= GRANT_CPU;
            end else begin
              ram_addr   <= dbg_addr;
              ram_din    <= dbg_wdata;
              ram_we     <= dbg_we;
              rd_q       <= !dbg_we;
              last_grant <= GRANT_DBG;
            end
          end
        end
        ACCESS: begin
          state   <= RESP;
          ram_we  <= 1'b0;
          cpu_ack <= (last_grant == GRANT_CPU);
          dbg_ack <= (last_grant == GRANT_DBG);
        end
        RESP: begin
          state   <= IDLE;
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          if (rd_q) begin
            if (last_grant == GRANT_CPU) cpu_rdata_q <= ram_dout;
            else                         dbg_rdata_q <= ram_dout;
          end
        end
        default: begin
          state   <= IDLE;
          ram_we  <= 1'b0;
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts the winner and
// read data of each access; a monitor pops expectations whenever an ack appears.
module tb_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [1:0]    cpu_mem_cmd;
  logic [AW-1:0] cpu_mem_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_cmd(cpu_mem_cmd), .cpu_mem_addr(cpu_mem_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment RAM: synchronous write, registered read.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  // Reference memory contents and arbitration history.
  logic [DW-1:0] mem_model [0:(1<<AW)-1];
  logic          mdl_last_dbg;

  typedef struct packed {
    logic          is_dbg;
    logic          is_rd;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expectation; acks must be single-cycle pulses.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (!reset && (cpu_ack || dbg_ack)) begin
      exp_t e;
      chk("ack_pulse_width", 32'(prev_ack), 32'd0);
      chk("ack_one_port", 32'(cpu_ack && dbg_ack), 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual cpu=%0d dbg=%0d required none", cpu_ack, dbg_ack);
      end else begin
        e = sb_q.pop_front();
        chk("ack_port_dbg", 32'(dbg_ack), 32'(e.is_dbg));
        if (e.is_rd) chk("rdata", 32'(e.is_dbg ? dbg_rdata : cpu_rdata), 32'(e.rdata));
      end
    end
    prev_ack <= cpu_ack || dbg_ack;
  end

  // One arbitration opportunity, entered and left at a negedge.
  task automatic do_round(input logic [1:0] cmd, input logic [AW-1:0] caddr,
                          input logic [DW-1:0] cdata, input logic dreq, input logic dwe,
                          input logic [AW-1:0] daddr, input logic [DW-1:0] ddata);
    logic creq, win_dbg, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_t e;
    cpu_mem_cmd = cmd; cpu_mem_addr = caddr; cpu_wdata = cdata;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = ddata;
    creq = (cmd == 2'b01) || (cmd == 2'b10);
    if (!creq && !dreq) begin
      @(negedge clk);
      chk("idle_ram_we", 32'(ram_we), 32'd0);
      chk("idle_stall", 32'(cpu_stall), 32'd0);
      return;
    end
    // Winner: lone requester; on contention CPU (fixed) or the port not served last (RR).
    if (creq && dreq) win_dbg = RR ? !mdl_last_dbg : 1'b0;
    else              win_dbg = dreq;
    wr = win_dbg ? dwe : (cmd == 2'b01);
    a  = win_dbg ? daddr : caddr;
    d  = win_dbg ? ddata : cdata;
    if (wr) mem_model[a] = d;
    e.is_dbg = win_dbg;
    e.is_rd  = !wr;
    e.rdata  = mem_model[a];
    sb_q.push_back(e);
    mdl_last_dbg = win_dbg;
    @(negedge clk);  // access cycle
    chk("acc_ram_we", 32'(ram_we), 32'(wr));
    chk("acc_ram_addr", 32'(ram_addr), 32'(a));
    if (wr) chk("acc_ram_din", 32'(ram_din), 32'(d));
    chk("acc_stall", 32'(cpu_stall), 32'(creq));
    // Requester inputs change after the grant and must be ignored.
    cpu_mem_addr = cpu_mem_addr + AW'(1);
    cpu_wdata = ~cpu_wdata;
    dbg_addr = ~dbg_addr;
    dbg_wdata = ~dbg_wdata;
    @(negedge clk);  // response cycle
    chk("resp_ram_we", 32'(ram_we), 32'd0);
    chk("resp_stall", 32'(cpu_stall), 32'(creq && win_dbg));
    @(negedge clk);
  endtask

  task automatic rnd_round();
    logic [1:0] cmd;
    cmd = 2'($urandom_range(0, 3));
    do_round(cmd, AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom);
      ram[i] = v;
      mem_model[i] = v;
    end
    ram[5] = 16'hBEEF;       mem_model[5] = 16'hBEEF;
    ram[9'h010] = 16'h5A5A;  mem_model[9'h010] = 16'h5A5A;
    mdl_last_dbg = 1'b1;
    reset = 1'b1;
    cpu_mem_cmd = 2'b00; cpu_mem_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset values.
    @(negedge clk);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
    reset = 1'b0;

    // CPU read of a known word, then debug write and CPU read-back.
    do_round(2'b10, 9'h005, 16'h0, 1'b0, 1'b0, '0, '0);
    do_round(2'b00, '0, '0, 1'b1, 1'b1, 9'h1FF, 16'h1234);
    do_round(2'b10, 9'h1FF, 16'h0, 1'b0, 1'b0, '0, '0);
    // Address changes during the access (3 -> 4) are ignored.
    do_round(2'b10, 9'h003, 16'h0, 1'b0, 1'b0, '0, '0);
    // Command 11 alone is no request.
    do_round(2'b11, 9'h007, 16'hFFFF, 1'b0, 1'b0, '0, '0);
    do_round(2'b11, 9'h008, 16'hFFFF, 1'b0, 1'b1, '0, '0);

    // Reset during a CPU write access, before the RAM edge.
    cpu_mem_cmd = 2'b01; cpu_mem_addr = 9'h010; cpu_wdata = 16'hAAAA;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ram_we", 32'(ram_we), 32'd0);
    chk("midrst_ram_addr", 32'(ram_addr), 32'd0);
    chk("midrst_ram_din", 32'(ram_din), 32'd0);
    chk("midrst_acks", 32'({cpu_ack, dbg_ack}), 32'd0);
    chk("midrst_rdata", 32'({cpu_rdata, dbg_rdata}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cpu_mem_cmd = 2'b00;
    mdl_last_dbg = 1'b1;
    @(negedge clk);
    chk("midrst_ram_kept", 32'(ram[9'h010]), 32'(mem_model[9'h010]));

    // Sustained contention: both ports keep requesting reads.
    for (int i = 0; i < 8; i++)
      do_round(2'b10, AW'($urandom), '0, 1'b1, 1'b0, AW'($urandom), '0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) rnd_round();

    cpu_mem_cmd = 2'b00; dbg_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-high reset, reset.
REQ-002 The block SHALL take parameter AW, default 9: memory address width.
REQ-003 The block SHALL take parameter DW, default 16: memory data width.
REQ-004 The block SHALL have the following ports, one per line as name  direction  width  meaning:
  clk  in  1  rising-edge clock
  reset  in  1  async active-high reset
  cpu_mem_cmd  in  2  CPU command: 00 none, 01 write, 10 read, 11 treated as none
  cpu_mem_addr  in  AW  CPU address
  cpu_wdata  in  DW  CPU write data
  cpu_rdata  out  DW  CPU read data, valid while cpu_ack=1
  cpu_ack  out  1  one-cycle CPU completion pulse
  cpu_stall  out  1  CPU request pending and not yet acknowledged
  dbg_req  in  1  debug/loader request
  dbg_we  in  1  debug write=1, read=0
  dbg_addr  in  AW  debug address
  dbg_wdata  in  DW  debug write data
  dbg_rdata  out  DW  debug read data, valid while dbg_ack=1
  dbg_ack  out  1  one-cycle debug completion pulse
  ram_addr  out  AW  RAM address
  ram_we  out  1  RAM write enable
  ram_din  out  DW  RAM write data
  ram_dout  in  DW  RAM read data, valid one cycle after address is sampled

Function
REQ-005 The block SHALL implement the FSM states IDLE, ACCESS and RESP, with the transitions IDLE->ACCESS on any request, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-006 In IDLE, the block SHALL sample requests at the clock edge; cpu_req = (cpu_mem_cmd==01 or 10), and dbg_req is taken as is.
REQ-007 On entering ACCESS, the block SHALL latch the winner's address, write flag and write data; requester input changes after that edge SHALL be ignored until the next IDLE.
REQ-008 In ACCESS, the block SHALL drive ram_addr and ram_din from the latched values and set ram_we=1 only for a write; in all other states ram_we=0.
REQ-009 In RESP, the block SHALL pulse the winner's ack for exactly one cycle and drive its rdata from ram_dout for reads (rdata is don't-care on writes).
REQ-010 Latency SHALL be: request sampled at edge E0, RAM access at E1, ack high between E1 and E2, and the next arbitration at E3; this gives a throughput of one access per 3 cycles.
REQ-011 A requester SHALL hold its request until it sees ack and drop it before E3; a request still present at E3 SHALL be serviced again.
REQ-012 cpu_stall SHALL be combinational: cpu_req AND NOT cpu_ack.
REQ-013 With a single requester active, that requester SHALL be granted with no added delay.
REQ-014 On simultaneous requests, the winner SHALL be chosen per REQ-019/REQ-020; the loser SHALL remain pending and be served at the next IDLE if it still requests.
REQ-015 A last_grant register SHALL record the port served by each ACCESS.
REQ-016 ram_addr and ram_din SHALL hold their last values outside ACCESS; they are don't-care for the RAM because ram_we=0.

Reset
REQ-017 Reset assertion SHALL immediately force the state to IDLE, ram_we=0, cpu_ack=0, dbg_ack=0, ram_addr=0, ram_din=0, cpu_rdata=0, dbg_rdata=0 and last_grant=DBG.
REQ-018 Reset asserted mid-ACCESS SHALL abandon the access with no ack; a write is not committed if reset is asserted before E1. After release, arbitration SHALL resume at the first edge in IDLE.

Configuration
REQ-019 With macro MEM_ARBITER_RR_EN defined, contention SHALL be resolved round-robin: the port not in last_grant wins, so the CPU wins the first contention after reset.
REQ-020 Without MEM_ARBITER_RR_EN, the CPU SHALL always win contention; the debug port may starve. last_grant is still maintained but unused.

Verification
REQ-021 CPU read: cpu_mem_cmd=10, addr 0x005, RAM[5]=0xBEEF -> ram_we=0 and ram_addr=0x005 in ACCESS; cpu_ack pulses with cpu_rdata=0xBEEF two cycles after the sample edge; cpu_stall drops during the ack cycle.
REQ-022 Debug write: dbg_req=1, dbg_we=1, addr 0x1FF, data 0x1234 -> ram_we pulses for exactly one cycle with ram_addr=0x1FF and ram_din=0x1234; dbg_ack pulses once; a later CPU read of 0x1FF returns 0x1234.
REQ-023 Contention with RR_EN: both ports continuously request -> grants alternate CPU, DBG, CPU, DBG with one ack every 3 cycles. Without RR_EN: only cpu_ack occurs and dbg_ack stays 0.
REQ-024 Reset mid-write: CPU write 0xAAAA to 0x010 with reset asserted in ACCESS before the RAM edge -> no ack, RAM[0x010] unchanged, and all outputs are 0 immediately.
REQ-025 Address change: CPU alters cpu_mem_addr from 0x003 to 0x004 during ACCESS -> ram_addr stays 0x003 and cpu_rdata=RAM[3].
REQ-026 cpu_mem_cmd=11 with dbg_req=0 -> the block stays in IDLE, with no ram_we and no ack.
